adc_readout_seq: RTL and testbench



---
 rtl/adc_readout_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_adc_readout_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_seq.sv
// -----------------------------------------------------------------------------
// adc_readout_seq
//   Readout-side responder for the exposure/readout frame handshake (CLK_HS
//   domain). Accepts the exposure FSM's FSMIND1 request with FSMIND1ACK, then
//   scans C_NUM_ROWS rows: row select + settle, one-cycle sample pulse,
//   conversion window, FIFO-gated row strobe. After the last row it raises
//   FSMIND0 and waits for FSMIND0ACK before returning to idle.
//
//   Optional feature macro: READOUT_TIMEOUT_EN
//     defined   : S_DONE gives up after C_TIMEOUT cycles without FSMIND0ACK,
//                 sets the sticky TIMEOUT_ERR flag and returns to S_IDLE.
//     undefined : S_DONE waits indefinitely, TIMEOUT_ERR is tied to 0.
//
// Ports
//   CLK_HS, RESET  readout clock, synchronous active-high reset
//   FSMIND1        readout request (async, synchronized internally)
//   FSMIND0ACK     frame accepted by exposure FSM (async, synchronized)
//   FIFO_FULL      downstream sample FIFO full (CLK_HS synchronous)
//   FSMIND1ACK     request accepted / readout in progress
//   FSMIND0        readout complete, held for the whole of S_DONE
//   ROW_SEL        current row index
//   ADC_SAMPLE     one-cycle sample pulse per row
//   ADC_CONV       conversion window, C_CONV cycles per row
//   ROW_STROBE     one-cycle row-data-ready pulse for the FIFO write
//   FRAME_CNT      completed frames (wraps)
//   TIMEOUT_ERR    sticky handshake-timeout flag
//   rd_stat        one-hot state code for debug readback
// -----------------------------------------------------------------------------
module adc_readout_seq #(
   parameter int unsigned C_NUM_ROWS = 160,
   parameter int unsigned C_SETTLE   = 4,
   parameter int unsigned C_CONV     = 20,
   parameter int unsigned C_TIMEOUT  = 1000000
) (
   input  logic        CLK_HS,
   input  logic        RESET,
   input  logic        FSMIND1,
   input  logic        FSMIND0ACK,
   input  logic        FIFO_FULL,
   output logic        FSMIND1ACK,
   output logic        FSMIND0,
   output logic [7:0]  ROW_SEL,
   output logic        ADC_SAMPLE,
   output logic        ADC_CONV,
   output logic        ROW_STROBE,
   output logic [31:0] FRAME_CNT,
   output logic        TIMEOUT_ERR,
   output logic [7:0]  rd_stat
);

   if (C_NUM_ROWS < 1 || C_NUM_ROWS > 255 || C_SETTLE < 1 || C_CONV < 1 ||
       C_TIMEOUT < 1) begin : g_bad_cfg
      $error("adc_readout_seq: parameter out of range");
   end

   localparam logic [7:0] LAST_ROW = 8'(C_NUM_ROWS - 1);

   // State encoding doubles as the rd_stat debug code.
   typedef enum logic [5:0] {
      S_IDLE     = 6'h01,
      S_SETTLE   = 6'h02,
      S_SAMPLE   = 6'h04,
      S_CONV     = 6'h08,
      S_ROW_NEXT = 6'h10,
      S_DONE     = 6'h20
   } state_t;

   state_t      state_q, state_d;
   logic        f1_m_q, f1_s_q, f0a_m_q, f0a_s_q;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  row_q, row_d;
   logic        ack1_q, ack1_d;
   logic        ind0_q, ind0_d;
   logic        smp_q, smp_d;
   logic        conv_q, conv_d;
`ifdef READOUT_TIMEOUT_EN
   logic        tmo_err_q, tmo_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      row_d       = row_q;
      ack1_d      = ack1_q;
      ind0_d      = ind0_q;
      smp_d       = 1'b0;
      conv_d      = 1'b0;
`ifdef READOUT_TIMEOUT_EN
      tmo_err_d   = tmo_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Both synchronized levels must agree so a stale ACK from the
            // previous frame cannot retrigger a scan.
            if (f1_s_q && !f0a_s_q) begin
               state_d = S_SETTLE;
               ack1_d  = 1'b1;
               row_d   = 8'd0;
               cnt_d   = 32'd0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == C_SETTLE - 1) begin
               state_d = S_SAMPLE;
               smp_d   = 1'b1;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_SAMPLE: begin
            state_d = S_CONV;
            conv_d  = 1'b1;
            cnt_d   = 32'd0;
         end
         S_CONV: begin
            if (cnt_q == C_CONV - 1) begin
               state_d = S_ROW_NEXT;
               cnt_d   = 32'd0;
            end else begin
               conv_d = 1'b1;
               cnt_d  = cnt_q + 32'd1;
            end
         end
         S_ROW_NEXT: begin
            if (!FIFO_FULL) begin
               cnt_d = 32'd0;
               if (row_q < LAST_ROW) begin
                  row_d   = row_q + 8'd1;
                  state_d = S_SETTLE;
               end else begin
                  frame_cnt_d = frame_cnt_q + 32'd1;
                  ind0_d      = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (f0a_s_q) begin
               ind0_d  = 1'b0;
               ack1_d  = 1'b0;
               state_d = S_IDLE;
            end
`ifdef READOUT_TIMEOUT_EN
            else if (cnt_q == C_TIMEOUT - 1) begin
               tmo_err_d = 1'b1;
               ind0_d    = 1'b0;
               ack1_d    = 1'b0;
               cnt_d     = 32'd0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
            ack1_d  = 1'b0;
            ind0_d  = 1'b0;
            cnt_d   = 32'd0;
         end
      endcase
   end

   always_ff @(posedge CLK_HS) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         f1_m_q      <= 1'b0;
         f1_s_q      <= 1'b0;
         f0a_m_q     <= 1'b0;
         f0a_s_q     <= 1'b0;
         cnt_q       <= 32'd0;
         frame_cnt_q <= 32'd0;
         row_q       <= 8'd0;
         ack1_q      <= 1'b0;
         ind0_q      <= 1'b0;
         smp_q       <= 1'b0;
         conv_q      <= 1'b0;
`ifdef READOUT_TIMEOUT_EN
         tmo_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         f1_m_q      <= FSMIND1;
         f1_s_q      <= f1_m_q;
         f0a_m_q     <= FSMIND0ACK;
         f0a_s_q     <= f0a_m_q;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         row_q       <= row_d;
         ack1_q      <= ack1_d;
         ind0_q      <= ind0_d;
         smp_q       <= smp_d;
         conv_q      <= conv_d;
`ifdef READOUT_TIMEOUT_EN
         tmo_err_q   <= tmo_err_d;
`endif
      end
   end

   assign FSMIND1ACK = ack1_q;
   assign FSMIND0    = ind0_q;
   assign ROW_SEL    = row_q;
   assign ADC_SAMPLE = smp_q;
   assign ADC_CONV   = conv_q;
   assign FRAME_CNT  = frame_cnt_q;
   assign rd_stat    = {2'b00, state_q};
   // Strobe is decoded from the state flop and the synchronous FIFO_FULL so it
   // lands in the same cycle the FIFO is seen not-full, while ROW_SEL still
   // names the row being written.
   assign ROW_STROBE = (state_q == S_ROW_NEXT) && !FIFO_FULL;
`ifdef READOUT_TIMEOUT_EN
   assign TIMEOUT_ERR = tmo_err_q;
`else
   assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_adc_readout_seq.sv
module tb_adc_readout_seq;
   localparam int unsigned N_ROWS  = 160;
   localparam int unsigned SETTLE  = 4;
   localparam int unsigned CONV    = 20;
   localparam int unsigned ROW_CYC = SETTLE + 1 + CONV + 1;
`ifdef READOUT_TIMEOUT_EN
   localparam int unsigned TMO     = 100;
   localparam logic        EXP_TMO = 1'b1;
`else
   localparam int unsigned TMO     = 1000000;
   localparam logic        EXP_TMO = 1'b0;
`endif

   logic        CLK_HS = 1'b0;
   logic        RESET, FSMIND1, FSMIND0ACK, FIFO_FULL;
   logic        FSMIND1ACK, FSMIND0, ADC_SAMPLE, ADC_CONV, ROW_STROBE, TIMEOUT_ERR;
   logic [7:0]  ROW_SEL, rd_stat;
   logic [31:0] FRAME_CNT;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb_rows[$];
   logic [7:0] mon_exp;

   adc_readout_seq #(
      .C_NUM_ROWS(N_ROWS), .C_SETTLE(SETTLE), .C_CONV(CONV), .C_TIMEOUT(TMO)
   ) dut (
      .CLK_HS(CLK_HS), .RESET(RESET), .FSMIND1(FSMIND1), .FSMIND0ACK(FSMIND0ACK),
      .FIFO_FULL(FIFO_FULL), .FSMIND1ACK(FSMIND1ACK), .FSMIND0(FSMIND0),
      .ROW_SEL(ROW_SEL), .ADC_SAMPLE(ADC_SAMPLE), .ADC_CONV(ADC_CONV),
      .ROW_STROBE(ROW_STROBE), .FRAME_CNT(FRAME_CNT), .TIMEOUT_ERR(TIMEOUT_ERR),
      .rd_stat(rd_stat)
   );

   always #5 CLK_HS = ~CLK_HS;

   // Scoreboard consumer: every strobe must match the next expected row.
   always @(negedge CLK_HS) begin
      if (ROW_STROBE) begin
         checks++;
         if (sb_rows.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: ROW_SEL=%0d, no row expected", ROW_SEL);
         end else begin
            mon_exp = sb_rows.pop_front();
            if (ROW_SEL !== mon_exp) begin
               errors++;
               $display("FAIL strobe_row: ROW_SEL=%0d expected %0d", ROW_SEL, mon_exp);
            end
         end
      end
   end

   task automatic test_reset();
      RESET = 1'b1; FSMIND1 = 1'b0; FSMIND0ACK = 1'b0; FIFO_FULL = 1'b0;
      repeat (3) @(negedge CLK_HS);
      checks++;
      if ({FSMIND1ACK, FSMIND0, ROW_SEL, ADC_SAMPLE, ADC_CONV, ROW_STROBE,
           FRAME_CNT, TIMEOUT_ERR, rd_stat} !== {46'd0, 8'h01}) begin
         errors++;
         $display("FAIL reset_state: ack=%b ind0=%b row=%0d frames=%0d stat=%h expected all 0, stat 01",
                  FSMIND1ACK, FSMIND0, ROW_SEL, FRAME_CNT, rd_stat);
      end
      RESET = 1'b0;
      repeat (3) @(negedge CLK_HS);
      checks++;
      if ({FSMIND1ACK, rd_stat} !== {1'b0, 8'h01}) begin
         errors++;
         $display("FAIL idle_hold: ack=%b stat=%h expected 0/01", FSMIND1ACK, rd_stat);
      end
   endtask

   // Raise the request (and drop ACK together); expect FSMIND1ACK on edge 3.
   task automatic start_request();
      FSMIND1 = 1'b1; FSMIND0ACK = 1'b0;
      for (int r = 0; r < int'(N_ROWS); r++) sb_rows.push_back(8'(r));
      repeat (2) @(negedge CLK_HS);
      checks++;
      if (FSMIND1ACK !== 1'b0) begin
         errors++;
         $display("FAIL req_early: FSMIND1ACK=%b before edge 3, expected 0", FSMIND1ACK);
      end
      @(negedge CLK_HS);
      checks++;
      if ({FSMIND1ACK, rd_stat, ROW_SEL} !== {1'b1, 8'h02, 8'h00}) begin
         errors++;
         $display("FAIL req_latency: ack=%b stat=%h row=%0d expected 1/02/0",
                  FSMIND1ACK, rd_stat, ROW_SEL);
      end
   endtask

   task automatic run_frame(input bit stall, input bit drop, input logic [31:0] exp_frames);
      int cyc = 0;
      int first_smp = -1;
      int strobes = 0;
      int stalled = 0;
      bit done = 1'b0;
      while (!done && cyc < 6000) begin
         @(negedge CLK_HS);
         cyc++;
         if (ADC_SAMPLE && first_smp < 0) first_smp = cyc;
         if (ROW_STROBE) strobes++;
         if (drop && cyc == 100) FSMIND1 = 1'b0;
         if (stall && ADC_SAMPLE && ROW_SEL == 8'd10) FIFO_FULL = 1'b1;
         if (FIFO_FULL && rd_stat == 8'h10) begin
            checks++;
            if ({ROW_STROBE, ADC_CONV, ROW_SEL} !== {2'b00, 8'd10}) begin
               errors++;
               $display("FAIL stall_hold: strobe=%b conv=%b row=%0d expected 0/0/10",
                        ROW_STROBE, ADC_CONV, ROW_SEL);
            end
            stalled++;
            if (stalled == 50) begin
               @(posedge CLK_HS);
               #1 FIFO_FULL = 1'b0;
            end
         end
         if (FSMIND0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_timeout: FSMIND0=0 after %0d cycles, expected 1", cyc);
      end
      checks++;
      if (first_smp != int'(SETTLE)) begin
         errors++;
         $display("FAIL first_sample: at cycle %0d expected %0d", first_smp, SETTLE);
      end
      checks++;
      if (cyc != int'(N_ROWS * ROW_CYC) + (stall ? 50 : 0)) begin
         errors++;
         $display("FAIL scan_length: %0d cycles expected %0d", cyc,
                  int'(N_ROWS * ROW_CYC) + (stall ? 50 : 0));
      end
      checks++;
      if (strobes != int'(N_ROWS) || sb_rows.size() != 0) begin
         errors++;
         $display("FAIL strobe_count: %0d strobes, %0d rows left, expected %0d/0",
                  strobes, sb_rows.size(), N_ROWS);
      end
      checks++;
      if ({FRAME_CNT, rd_stat, FSMIND1ACK, ROW_SEL} !== {exp_frames, 8'h20, 1'b1, 8'(N_ROWS - 1)}) begin
         errors++;
         $display("FAIL frame_end: frames=%0d stat=%h ack=%b row=%0d expected %0d/20/1/%0d",
                  FRAME_CNT, rd_stat, FSMIND1ACK, ROW_SEL, exp_frames, N_ROWS - 1);
      end
      if (stall) begin
         checks++;
         if (stalled != 50) begin
            errors++;
            $display("FAIL stall_cycles: %0d expected 50", stalled);
         end
      end
   endtask

   task automatic test_handshake_close();
      FSMIND1 = 1'b0; FSMIND0ACK = 1'b1;
      repeat (2) @(negedge CLK_HS);
      checks++;
      if ({FSMIND0, FSMIND1ACK} !== 2'b11) begin
         errors++;
         $display("FAIL close_early: ind0=%b ack=%b expected 1/1", FSMIND0, FSMIND1ACK);
      end
      @(negedge CLK_HS);
      checks++;
      if ({FSMIND0, FSMIND1ACK, rd_stat, ROW_SEL} !== {2'b00, 8'h01, 8'(N_ROWS - 1)}) begin
         errors++;
         $display("FAIL close_latency: ind0=%b ack=%b stat=%h row=%0d expected 0/0/01/%0d",
                  FSMIND0, FSMIND1ACK, rd_stat, ROW_SEL, N_ROWS - 1);
      end
   endtask

   task automatic test_first_frame();
      start_request();
      run_frame(1'b0, 1'b0, 32'd1);
   endtask

   // Second frame straight out of DONE, with a FIFO stall and FSMIND1 dropped mid-scan.
   task automatic test_back_to_back();
      start_request();
      run_frame(1'b1, 1'b1, 32'd2);
   endtask

   task automatic test_done_hold();
`ifdef READOUT_TIMEOUT_EN
      int t_err = -1;
      for (int i = 1; i <= int'(TMO) + 5; i++) begin
         @(negedge CLK_HS);
         if (TIMEOUT_ERR && t_err < 0) begin
            t_err = i;
            checks++;
            if ({FSMIND0, FSMIND1ACK, rd_stat} !== {2'b00, 8'h01}) begin
               errors++;
               $display("FAIL timeout_exit: ind0=%b ack=%b stat=%h expected 0/0/01",
                        FSMIND0, FSMIND1ACK, rd_stat);
            end
         end
      end
      checks++;
      if (t_err != int'(TMO)) begin
         errors++;
         $display("FAIL timeout_cycle: TIMEOUT_ERR at %0d expected %0d", t_err, TMO);
      end
`else
      int bad = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge CLK_HS);
         if ({FSMIND0, FSMIND1ACK, TIMEOUT_ERR, rd_stat} !== {3'b110, 8'h20}) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL done_wait: left S_DONE or flagged timeout in %0d of 200 cycles, expected 0", bad);
      end
      test_handshake_close();
`endif
   endtask

   task automatic test_stale_ack();
      FSMIND1 = 1'b1; FSMIND0ACK = 1'b1;
      repeat (10) @(negedge CLK_HS);
      checks++;
      if ({FSMIND1ACK, rd_stat, TIMEOUT_ERR} !== {1'b0, 8'h01, EXP_TMO}) begin
         errors++;
         $display("FAIL stale_ack: ack=%b stat=%h terr=%b expected 0/01/%b",
                  FSMIND1ACK, rd_stat, TIMEOUT_ERR, EXP_TMO);
      end
   endtask

   task automatic test_reset_mid_scan();
      int n = 0;
      int ind0_seen = 0;
      start_request();
      while (ROW_SEL != 8'd80 && n < 3000) begin
         @(negedge CLK_HS);
         n++;
         if (FSMIND0) ind0_seen++;
      end
      checks++;
      if (ROW_SEL != 8'd80 || ind0_seen != 0) begin
         errors++;
         $display("FAIL mid_scan_reach: row=%0d ind0 cycles=%0d expected 80/0", ROW_SEL, ind0_seen);
      end
      RESET = 1'b1; FSMIND1 = 1'b0;
      @(negedge CLK_HS);
      checks++;
      if ({FSMIND1ACK, FSMIND0, ROW_SEL, ADC_SAMPLE, ADC_CONV, ROW_STROBE,
           FRAME_CNT, TIMEOUT_ERR, rd_stat} !== {46'd0, 8'h01}) begin
         errors++;
         $display("FAIL reset_mid_scan: ack=%b ind0=%b row=%0d frames=%0d terr=%b stat=%h expected all 0, stat 01",
                  FSMIND1ACK, FSMIND0, ROW_SEL, FRAME_CNT, TIMEOUT_ERR, rd_stat);
      end
      RESET = 1'b0; FSMIND0ACK = 1'b0;
      sb_rows.delete();
      repeat (20) @(negedge CLK_HS) if (FSMIND0 || FSMIND1ACK) ind0_seen++;
      checks++;
      if (ind0_seen != 0 || rd_stat !== 8'h01) begin
         errors++;
         $display("FAIL post_reset_idle: handshake cycles=%0d stat=%h expected 0/01", ind0_seen, rd_stat);
      end
   endtask

   task automatic test_wrap();
      force dut.frame_cnt_q = 32'hFFFF_FFFF;
      repeat (2) @(negedge CLK_HS);
      release dut.frame_cnt_q;
      repeat (2) @(negedge CLK_HS);
      checks++;
      if (FRAME_CNT !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_preload: FRAME_CNT=%h expected ffffffff", FRAME_CNT);
      end
      start_request();
      run_frame(1'b0, 1'b0, 32'd0);
      test_handshake_close();
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_handshake_close();
      test_back_to_back();
      test_done_hold();
      test_stale_ack();
      test_reset_mid_scan();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
